memory_loader: RTL and testbench

Initiator-side controller for the 4-byte memory_system store/addr/data interface, which on its own only responds to those signals.
- Write path: accepts bytes over a valid/ready handshake and writes them to sequential addresses with a clean setup/strobe/hold store pulse.
- Scan path: on command, walks all four addresses, samples the multiplexed memory output and presents each byte with a one-cycle valid.
- Sits between switch/button front-end logic and memory_system on the board top level.

---
 rtl/memory_loader_pkg.sv | 18 +
 rtl/memory_loader_timer.sv | 26 ++
 rtl/memory_loader.sv | 143 ++++++++++++++
 tb/tb_memory_loader.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/memory_loader_pkg.sv
// Shared types and default sizing for the memory_loader initiator.
package memory_loader_pkg;

  localparam int unsigned DEF_ADDR_W     = 2;
  localparam int unsigned DEF_DATA_W     = 8;
  localparam int unsigned DEF_STORE_HOLD = 1;
  localparam int unsigned DEF_SCAN_DIV   = 4;
  localparam int unsigned TIMER_W        = 16;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    STROBE,
    HOLD,
    SCAN
  } state_t;

endpackage

// File: rtl/memory_loader_timer.sv
// Loadable down-counter; tc is high on the last cycle of a loaded interval.
module loader_timer #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             tc
);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - CNT_W'(1);
    end
  end

  assign tc = (count == CNT_W'(1));

endmodule

// File: rtl/memory_loader.sv
// Write/scan initiator for the 4-byte memory_system store/addr/data interface.
// Define MEMORY_LOADER_WRAP_EN to let the write pointer wrap instead of saturating.
module memory_loader
  import memory_loader_pkg::*;
#(
  parameter int unsigned ADDR_W     = DEF_ADDR_W,
  parameter int unsigned DATA_W     = DEF_DATA_W,
  parameter int unsigned STORE_HOLD = DEF_STORE_HOLD,
  parameter int unsigned SCAN_DIV   = DEF_SCAN_DIV
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              start_scan,
  output logic [DATA_W-1:0] mem_data,
  output logic              mem_store,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] scan_byte,
  output logic [ADDR_W-1:0] scan_addr,
  output logic              scan_valid,
  output logic              busy,
  output logic              full
);

  localparam logic [ADDR_W-1:0] LAST = '1;

  state_t               state, next_state;
  logic [ADDR_W-1:0]    wr_ptr;
  logic                 full_next;
  logic                 ready_next;
  logic                 wr_fire;
  logic                 tmr_load;
  logic [TIMER_W-1:0]   tmr_val;
  logic                 tc;

  loader_timer #(
    .CNT_W(TIMER_W)
  ) u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (tmr_load),
    .load_val (tmr_val),
    .tc       (tc)
  );

  always_comb begin
    next_state = state;
    wr_fire    = 1'b0;
    tmr_load   = 1'b0;
    tmr_val    = '0;
    case (state)
      IDLE: begin
        // A write handshake takes priority; a coincident scan request is dropped.
        if (in_valid && in_ready) begin
          next_state = SETUP;
          wr_fire    = 1'b1;
        end else if (start_scan) begin
          next_state = SCAN;
          tmr_load   = 1'b1;
          tmr_val    = TIMER_W'(SCAN_DIV);
        end
      end
      SETUP: begin
        next_state = STROBE;
        tmr_load   = 1'b1;
        tmr_val    = TIMER_W'(STORE_HOLD);
      end
      STROBE: begin
        if (tc) next_state = HOLD;
      end
      HOLD: next_state = IDLE;
      SCAN: begin
        if (tc) begin
          if (mem_addr == LAST) begin
            next_state = IDLE;
          end else begin
            tmr_load = 1'b1;
            tmr_val  = TIMER_W'(SCAN_DIV);
          end
        end
      end
      default: next_state = IDLE;
    endcase

`ifdef MEMORY_LOADER_WRAP_EN
    full_next  = 1'b0;
    ready_next = (next_state == IDLE);
`else
    full_next  = full | ((state == HOLD) && (wr_ptr == LAST));
    ready_next = (next_state == IDLE) && !full_next;
`endif
  end

  // in_ready is registered from the next state so it stays low in the reset cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      wr_ptr     <= '0;
      full       <= 1'b0;
      in_ready   <= 1'b0;
      mem_data   <= '0;
      mem_addr   <= '0;
      scan_byte  <= '0;
      scan_addr  <= '0;
      scan_valid <= 1'b0;
    end else begin
      state      <= next_state;
      full       <= full_next;
      in_ready   <= ready_next;
      scan_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (wr_fire) begin
            mem_data <= in_data;
            mem_addr <= wr_ptr;
          end else if (next_state == SCAN) begin
            mem_addr <= '0;
          end
        end
        HOLD: begin
          wr_ptr   <= wr_ptr + ADDR_W'(1);
          mem_addr <= wr_ptr + ADDR_W'(1);
        end
        SCAN: begin
          if (tc) begin
            scan_byte  <= mem_rdata;
            scan_addr  <= mem_addr;
            scan_valid <= 1'b1;
            mem_addr   <= (mem_addr == LAST) ? wr_ptr : mem_addr + ADDR_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign mem_store = (state == STROBE);
  assign busy      = (state != IDLE);

endmodule

// File: tb/tb_memory_loader.sv
// Self-checking bench for memory_loader with a behavioural memory and loader model.
module tb_memory_loader;

  localparam int AW    = 2;
  localparam int DW    = 8;
  localparam int SH    = 1;
  localparam int SD    = 4;
  localparam int DEPTH = 1 << AW;
`ifdef MEMORY_LOADER_WRAP_EN
  localparam bit WRAP = 1'b1;
`else
  localparam bit WRAP = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic [DW-1:0] in_data;
  logic          in_valid;
  logic          in_ready;
  logic          start_scan;
  logic [DW-1:0] mem_data;
  logic          mem_store;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_rdata;
  logic [DW-1:0] scan_byte;
  logic [AW-1:0] scan_addr;
  logic          scan_valid;
  logic          busy;
  logic          full;

  int n_assert = 0;
  int n_fail   = 0;

  // reference model state
  logic [DW-1:0] m_mem [DEPTH];
  int            m_ptr;
  bit            m_full;

  // stand-in for memory_system: synchronous store, multiplexed read
  logic [DW-1:0] tbmem [DEPTH];
  always @(posedge clk) if (mem_store) tbmem[mem_addr] <= mem_data;
  assign mem_rdata = tbmem[mem_addr];

  always #5 clk = ~clk;

  memory_loader #(
    .ADDR_W(AW), .DATA_W(DW), .STORE_HOLD(SH), .SCAN_DIV(SD)
  ) dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .start_scan(start_scan), .mem_data(mem_data),
    .mem_store(mem_store), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .scan_byte(scan_byte), .scan_addr(scan_addr), .scan_valid(scan_valid),
    .busy(busy), .full(full)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 'h%0h expected 'h%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1; in_valid = 1'b0; start_scan = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_full", full, 0);
    chk("rst_store", mem_store, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_data", mem_data, 0);
    chk("rst_svalid", scan_valid, 0);
    chk("rst_sbyte", scan_byte, 0);
    chk("rst_saddr", scan_addr, 0);
    reset = 1'b0;
    m_ptr = 0; m_full = 1'b0;
    @(negedge clk);
    chk("rel_in_ready", in_ready, 1);
  endtask

  // one accepted write, checking the setup/strobe/hold timing around it
  task automatic write_byte(input logic [DW-1:0] d, input bit keep, input bit with_scan);
    int w = 0;
    in_data = d; in_valid = 1'b1;
    if (with_scan) start_scan = 1'b1;
    while (!in_ready && w < 50) begin @(negedge clk); w++; end
    chk("ready_wait", in_ready, 1);
    @(negedge clk);
    start_scan = 1'b0;
    if (!keep) in_valid = 1'b0;
    chk("wr_addr", mem_addr, m_ptr);
    chk("wr_data", mem_data, d);
    chk("wr_setup_store", mem_store, 0);
    chk("wr_busy", busy, 1);
    chk("wr_ready_low", in_ready, 0);
    for (int i = 0; i < SH; i++) begin
      @(negedge clk);
      chk("wr_strobe", mem_store, 1);
    end
    @(negedge clk);
    chk("wr_hold_store", mem_store, 0);
    chk("wr_hold_addr", mem_addr, m_ptr);
    m_mem[m_ptr] = d;
    if (m_ptr == DEPTH - 1 && !WRAP) m_full = 1'b1;
    m_ptr = (m_ptr + 1) % DEPTH;
    @(negedge clk);
    chk("wr_ready_back", in_ready, !m_full);
    chk("wr_idle", busy, 0);
    chk("wr_full", full, m_full);
    chk("wr_idle_addr", mem_addr, m_ptr);
  endtask

  task automatic attempt_write(input logic [DW-1:0] d, input bit keep);
    int stores = 0;
    if (!m_full) begin
      write_byte(d, keep, 1'b0);
    end else begin
      in_data = d; in_valid = 1'b1;
      repeat (8) begin @(negedge clk); if (mem_store) stores++; end
      chk("full_no_store", stores, 0);
      chk("full_ready", in_ready, 0);
      chk("full_busy", busy, 0);
      in_valid = 1'b0;
    end
  endtask

  task automatic do_scan();
    int k = 0;
    int stores = 0;
    start_scan = 1'b1;
    @(negedge clk);
    start_scan = 1'b0;
    chk("scan_busy", busy, 1);
    for (int cyc = 1; cyc <= DEPTH * SD + 2; cyc++) begin
      if (mem_store) stores++;
      if (scan_valid) begin
        chk("scan_time", cyc, (k + 1) * SD + 1);
        chk("scan_addr", scan_addr, k % DEPTH);
        chk("scan_byte", scan_byte, m_mem[k % DEPTH]);
        k++;
      end
      @(negedge clk);
    end
    chk("scan_count", k, DEPTH);
    chk("scan_stores", stores, 0);
    chk("scan_done", busy, 0);
    chk("scan_ret_addr", mem_addr, m_ptr);
  endtask

  initial begin
    int pulses;
    logic [DW-1:0] d;
    reset = 1'b1; in_data = '0; in_valid = 1'b0; start_scan = 1'b0;
    @(negedge clk);
    do_reset();

    // single write
    write_byte(8'hA5, 1'b0, 1'b0);
    chk("mem0", tbmem[0], 8'hA5);

    // back-to-back writes then a write attempt when full (lands at 0 when wrapping)
    do_reset();
    write_byte(8'h11, 1'b1, 1'b0);
    write_byte(8'h22, 1'b1, 1'b0);
    write_byte(8'h33, 1'b1, 1'b0);
    write_byte(8'h44, 1'b1, 1'b0);
    chk("full_after4", full, !WRAP);
    attempt_write(8'h99, 1'b0);
    do_scan();

    // write wins over a coincident scan request
    do_reset();
    write_byte(8'h5A, 1'b0, 1'b1);
    pulses = 0;
    repeat (DEPTH * SD + 2) begin @(negedge clk); if (scan_valid) pulses++; end
    chk("dropped_scan", pulses, 0);
    do_scan();

    // reset while the store strobe is high
    do_reset();
    d = 8'($urandom);
    in_data = d; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    chk("mid_strobe", mem_store, 1);
    m_mem[m_ptr] = d;
    do_reset();
    write_byte(8'($urandom), 1'b0, 1'b0);
    chk("post_rst_ptr", m_ptr, 1);

    // wrap/saturation demo: five writes 01..05
    do_reset();
    for (int i = 1; i <= 5; i++) attempt_write(8'(i), 1'b0);
    chk("five_full", full, !WRAP);
    do_scan();

    // randomized rounds
    for (int r = 0; r < 6; r++) begin
      if ($urandom_range(0, 1) == 1) do_reset();
      for (int n = $urandom_range(1, 6); n > 0; n--) begin
        attempt_write(8'($urandom), 1'($urandom_range(0, 1)));
        in_valid = 1'b0;
        repeat ($urandom_range(0, 3)) @(negedge clk);
      end
      in_valid = 1'b0;
      @(negedge clk);
      do_scan();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
